counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
Sequencing controller for the team's 8-bit count datapath: an incrementer feeding a bank of count registers.
Software or a host FSM programs a terminal value and a mode, then starts the block. It steps the count on each enable cycle, detects terminal count, and raises a pulse and a sticky interrupt. It supports one-shot and auto-reload operation with start/stop control, so one counter datapath can serve as an interval timer.

Parameters:
WIDTH, 8, width of count and period (minimum 2).

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request: capture period/auto_reload and arm the counter
stop  input  1  single-cycle request: abort the sequence, return to IDLE
period  input  WIDTH  terminal count value, sampled only when start is accepted
auto_reload  input  1  1 = periodic, 0 = one-shot; sampled with period
count_en  input  1  advance enable (prescaler tick); ignored outside RUN
irq_ack  input  1  clears irq and ovf
count  output  WIDTH  current count value (registered)
busy  output  1  high in ARM and RUN
tc_pulse  output  1  registered one-cycle pulse, high the cycle after terminal count is reached
irq  output  1  sticky terminal-count interrupt
ovf  output  1  sticky: terminal count occurred while irq was already pending
state_o  output  2  IDLE=0, ARM=1, RUN=2, DONE=3 (debug)

Behaviour:
- Reset (synchronous, at the clk edge with reset=1): state IDLE, count=0, busy=0, tc_pulse=0, irq=0, ovf=0, period_q=0, mode_q=0. Reset overrides every other input, including mid-sequence.
- tc_pulse defaults to 0 every cycle unless set as described below.
- IDLE:
  - start=1 → period_q<=period, mode_q<=auto_reload, count<=0, go to ARM.
  - stop has no effect in IDLE.
- ARM (exactly one cycle): count held at 0, busy=1.
  - stop=1 → IDLE.
  - Otherwise → RUN.
- RUN: busy=1.
  - stop=1 → IDLE, count<=0, no tc_pulse. stop beats a simultaneous terminal count.
  - Else if count_en=1 and count==period_q (terminal count):
    - tc_pulse<=1 and irq<=1.
    - mode_q=1 → count<=0, stay in RUN.
    - mode_q=0 → count holds period_q, go to DONE.
  - Else if count_en=1 → count<=count+1.
  - count_en=0 → count holds.
  - start is ignored in RUN; re-programming requires stop first.
- DONE: busy=0, count holds.
  - start=1 → capture new period/mode, count<=0, go to ARM. start beats stop if both are high.
  - stop=1 alone → IDLE, count<=0.
- Arithmetic: count never exceeds period_q, so the increment never wraps.
  - period=0 → terminal count on every enabled RUN cycle.
  - period=2^WIDTH-1 → full-range count; terminal count at 255 for WIDTH=8.
  - A sequence spans period_q+1 enabled cycles from count 0 to terminal count.
- Latency: start at edge N → ARM at N+1 → RUN at N+2. The first increment can occur at edge N+3.
- irq/ovf: set on terminal count, cleared by irq_ack.
  - Terminal count with irq_ack in the same cycle → irq stays 1 (set wins). ovf is not set.
  - Terminal count while irq=1 and irq_ack=0 → ovf<=1.
  - irq_ack clears ovf when no simultaneous overflow occurs.
- Outputs are registered only; no combinational path from input to output except through state.

Test Plan:
- Reset mid-run:
  - Stimulus: start with period=5, auto_reload=0; assert reset while count=3.
  - Required: the next edge gives count=0, IDLE, busy=0, irq=0; later count_en pulses do not move count.
- One-shot:
  - Stimulus: period=3, auto_reload=0, count_en held 1.
  - Required: count sequence 0,1,2,3; tc_pulse is a single cycle after count reaches 3; state DONE; count holds 3; irq=1 until irq_ack.
- Auto-reload:
  - Stimulus: period=2, auto_reload=1, count_en=1, run 9 enabled cycles.
  - Required: count 0,1,2,0,1,2,0,1,2; three tc_pulses 3 cycles apart; ovf=1 after the 2nd terminal count with no ack.
- Gated enable and period extremes:
  - Stimulus: period=0, count_en alternating 1/0.
  - Required: tc_pulse on every enabled RUN cycle, count stays 0.
  - Stimulus: period=255, count_en=1.
  - Required: terminal count after exactly 256 enabled RUN cycles, no wrap before it.
- Stop priority:
  - Stimulus: stop asserted in the same cycle as terminal count (count==period_q, count_en=1).
  - Required: IDLE, count=0, tc_pulse=0, irq unchanged.
- Ack race and restart:
  - Stimulus: irq_ack coincides with a terminal count.
  - Required: irq stays 1, ovf=0.
  - Stimulus: in DONE, start with period=1.
  - Required: ARM→RUN, count restarts from 0, new period used.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
//   Sequencing controller for an 8-bit style count datapath. A host programs a
//   terminal value (period) and a mode (one-shot / auto-reload), pulses start,
//   and the block steps the count on every count_en cycle while running. On
//   terminal count it raises a one-cycle tc_pulse and a sticky irq. A second
//   terminal count while irq is still pending sets the sticky ovf flag.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   start        request: capture period/auto_reload and arm (IDLE/DONE only)
//   stop         request: abort and return to IDLE
//   period       terminal count value, sampled when start is accepted
//   auto_reload  1 = periodic, 0 = one-shot, sampled with period
//   count_en     advance enable, only honoured in RUN
//   irq_ack      clears irq and ovf
//   count        current count value
//   busy         high in ARM and RUN
//   tc_pulse     one-cycle pulse the cycle after terminal count
//   irq          sticky terminal-count interrupt
//   ovf          sticky: terminal count while irq already pending
//   state_o      IDLE=0, ARM=1, RUN=2, DONE=3
module counter_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] period,
  input  logic             auto_reload,
  input  logic             count_en,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             irq,
  output logic             ovf,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             irq_q, irq_d;
  logic             ovf_q, ovf_d;

  // Terminal count event; stop has priority and suppresses it entirely.
  logic tc_hit;
  assign tc_hit = (state_q == RUN) && !stop && count_en && (count_q == period_q);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_d unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = ARM;
      ARM:  state_d = stop ? IDLE : RUN;
      RUN: begin
        if (stop)                 state_d = IDLE;
        else if (tc_hit && !mode_q) state_d = DONE;
      end
      DONE: begin
        // start wins over stop when both are requested.
        if (start)     state_d = ARM;
        else if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next-value logic
  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    tc_d     = tc_hit;

    // Setting irq beats a simultaneous ack; overflow only counts when the
    // pending irq is not being acknowledged in the same cycle.
    irq_d = tc_hit ? 1'b1 : (irq_ack ? 1'b0 : irq_q);
    if (tc_hit && irq_q && !irq_ack) ovf_d = 1'b1;
    else if (irq_ack)                ovf_d = 1'b0;
    else                             ovf_d = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          period_d = period;
          mode_d   = auto_reload;
          count_d  = '0;
        end else if (stop) begin
          count_d  = '0;
        end
      end
      ARM: count_d = '0;
      RUN: begin
        if (stop)          count_d = '0;
        else if (tc_hit)   count_d = mode_q ? '0 : count_q;
        else if (count_en) count_d = count_q + 1'b1;
      end
      default: count_d = '0;
    endcase
  end

  assign count    = count_q;
  assign busy     = (state_q == ARM) || (state_q == RUN);
  assign tc_pulse = tc_q;
  assign irq      = irq_q;
  assign ovf      = ovf_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Testbench for counter_seq_ctrl: directed scenarios with literal expectations
// plus a randomized phase, all continuously compared against a behavioural
// model of the controller.
module tb_counter_seq_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [WIDTH-1:0] period = '0;
  logic             auto_reload = 1'b0;
  logic             count_en = 1'b0;
  logic             irq_ack = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy, tc_pulse, irq, ovf;
  logic [1:0]       state_o;

  int checks = 0;
  int errors = 0;

  counter_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .period(period),
    .auto_reload(auto_reload), .count_en(count_en), .irq_ack(irq_ack),
    .count(count), .busy(busy), .tc_pulse(tc_pulse), .irq(irq), .ovf(ovf),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase names: 0 idle, 1 arming, 2 running, 3 done.
  int  m_phase = 0;
  int  m_count = 0;
  int  m_period = 0;
  bit  m_periodic = 0;
  bit  m_tc = 0, m_irq = 0, m_ovf = 0;
  bit  m_valid = 0;

  always @(posedge clk) begin
    bit hit;
    if (reset) begin
      m_phase = 0; m_count = 0; m_period = 0; m_periodic = 0;
      m_tc = 0; m_irq = 0; m_ovf = 0; m_valid = 1;
    end else begin
      hit = (m_phase == 2) && !stop && count_en && (m_count == m_period);
      m_ovf = (hit && m_irq && !irq_ack) ? 1 : (irq_ack ? 0 : m_ovf);
      m_irq = hit ? 1 : (irq_ack ? 0 : m_irq);
      m_tc  = hit;
      if (m_phase == 0 || m_phase == 3) begin
        if (start) begin
          m_period = period; m_periodic = auto_reload; m_count = 0; m_phase = 1;
        end else if (stop && m_phase == 3) begin
          m_count = 0; m_phase = 0;
        end
      end else if (m_phase == 1) begin
        m_phase = stop ? 0 : 2;
      end else begin
        if (stop) begin
          m_count = 0; m_phase = 0;
        end else if (hit) begin
          if (m_periodic) m_count = 0;
          else m_phase = 3;
        end else if (count_en) begin
          m_count = m_count + 1;
        end
      end
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_count", 32'(count), 32'(m_count));
      check("model_state", 32'(state_o), 32'(m_phase));
      check("model_busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      check("model_tc", 32'(tc_pulse), 32'(m_tc));
      check("model_irq", 32'(irq), 32'(m_irq));
      check("model_ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse with given program, leaves the block in RUN with count 0
  task automatic launch(input int p, input bit ar);
    period = WIDTH'(p); auto_reload = ar; start = 1'b1;
    tick();
    start = 1'b0;
    check("launch_arm_state", 32'(state_o), 32'd1);
    tick();
    check("launch_run_state", 32'(state_o), 32'd2);
  endtask

  int tc_seen;
  int exp_cnt[9] = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
  bit exp_tc[9]  = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_tc", 32'(tc_pulse), 32'd0);
    reset = 1'b0;
    tick();

    // Reset mid-run
    launch(5, 0);
    count_en = 1'b1;
    repeat (3) tick();
    check("midrun_count3", 32'(count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrun_rst_count", 32'(count), 32'd0);
    check("midrun_rst_state", 32'(state_o), 32'd0);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_irq", 32'(irq), 32'd0);
    repeat (3) tick();
    check("midrun_idle_count", 32'(count), 32'd0);
    count_en = 1'b0;

    // One-shot, period 3
    launch(3, 0);
    count_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("oneshot_count", 32'(count), 32'(i));
      check("oneshot_no_tc", 32'(tc_pulse), 32'd0);
    end
    tick();
    check("oneshot_tc", 32'(tc_pulse), 32'd1);
    check("oneshot_done", 32'(state_o), 32'd3);
    check("oneshot_hold", 32'(count), 32'd3);
    check("oneshot_irq", 32'(irq), 32'd1);
    check("oneshot_busy", 32'(busy), 32'd0);
    tick();
    check("oneshot_tc_single", 32'(tc_pulse), 32'd0);
    check("oneshot_hold2", 32'(count), 32'd3);
    check("oneshot_irq_sticky", 32'(irq), 32'd1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("oneshot_ack", 32'(irq), 32'd0);
    count_en = 1'b0;

    // Auto-reload, period 2, nine enabled cycles (restart from DONE)
    launch(2, 1);
    count_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("reload_count", 32'(count), 32'(exp_cnt[i]));
      check("reload_tc", 32'(tc_pulse), 32'(exp_tc[i]));
      if (i == 2) check("reload_ovf_first", 32'(ovf), 32'd0);
      if (i == 5) check("reload_ovf_second", 32'(ovf), 32'd1);
    end
    count_en = 1'b0;
    stop = 1'b1; irq_ack = 1'b1;
    tick();
    stop = 1'b0; irq_ack = 1'b0;
    check("reload_stop_state", 32'(state_o), 32'd0);
    check("reload_ack_ovf", 32'(ovf), 32'd0);

    // Period 0 with alternating enable
    launch(0, 1);
    for (int i = 0; i < 6; i++) begin
      count_en = (i % 2 == 0);
      tick();
      check("p0_tc", 32'(tc_pulse), 32'(i % 2 == 0));
      check("p0_count", 32'(count), 32'd0);
    end
    count_en = 1'b0;
    stop = 1'b1; irq_ack = 1'b1;
    tick();
    stop = 1'b0; irq_ack = 1'b0;

    // Period 255: terminal count on the 256th enabled cycle, no earlier wrap
    launch(255, 0);
    count_en = 1'b1;
    tc_seen = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (tc_pulse) tc_seen++;
    end
    check("p255_no_early_tc", 32'(tc_seen), 32'd0);
    check("p255_count", 32'(count), 32'd255);
    tick();
    check("p255_tc", 32'(tc_pulse), 32'd1);
    check("p255_done", 32'(state_o), 32'd3);
    check("p255_hold", 32'(count), 32'd255);
    count_en = 1'b0;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;

    // Stop beats terminal count; irq left pending from an earlier TC
    launch(1, 1);
    count_en = 1'b1;
    tick();
    tick();
    check("stopprio_first_tc", 32'(tc_pulse), 32'd1);
    check("stopprio_irq_set", 32'(irq), 32'd1);
    tick();
    check("stopprio_at_tc", 32'(count), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0; count_en = 1'b0;
    check("stopprio_state", 32'(state_o), 32'd0);
    check("stopprio_count", 32'(count), 32'd0);
    check("stopprio_tc", 32'(tc_pulse), 32'd0);
    check("stopprio_irq", 32'(irq), 32'd1);
    check("stopprio_ovf", 32'(ovf), 32'd0);

    // Ack coinciding with terminal count: irq stays, ovf not set
    launch(0, 0);
    count_en = 1'b1; irq_ack = 1'b1;
    tick();
    count_en = 1'b0; irq_ack = 1'b0;
    check("ackrace_irq", 32'(irq), 32'd1);
    check("ackrace_ovf", 32'(ovf), 32'd0);
    check("ackrace_done", 32'(state_o), 32'd3);

    // Restart from DONE with period 1
    launch(1, 0);
    check("restart_count0", 32'(count), 32'd0);
    count_en = 1'b1;
    tick();
    check("restart_count1", 32'(count), 32'd1);
    check("restart_no_tc", 32'(tc_pulse), 32'd0);
    tick();
    check("restart_tc", 32'(tc_pulse), 32'd1);
    check("restart_done", 32'(state_o), 32'd3);
    check("restart_hold", 32'(count), 32'd1);
    count_en = 1'b0;

    // Randomized phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 29) == 0);
      period      = ($urandom_range(0, 15) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
      auto_reload = $urandom_range(0, 1) == 1;
      count_en    = ($urandom_range(0, 3) != 0);
      irq_ack     = ($urandom_range(0, 9) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; count_en = 1'b0; irq_ack = 1'b0;
    tick();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
